// File: rtl/ir_pkg.sv
// Shared types and constants for the IR sample sequencer.
// Holds the FSM state encoding and the saturating subtract used by ambient cancellation.
package ir_pkg;

  localparam int NUM_CH = 8;
  localparam int RES_W  = 12;
  localparam int CH_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CONV,
    ST_WAIT,
    ST_NEXT,
    ST_PUBLISH
  } ir_state_t;

  function automatic logic [RES_W-1:0] sat_sub(input logic [RES_W-1:0] a,
                                               input logic [RES_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/ir_sample_bank.sv
// Double-buffered reading storage: the shadow bank fills during acquisition and is
// copied whole into the published bank, which drives the combinational read port.
module ir_sample_bank
  import ir_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_idx,
  input  logic [RES_W-1:0] wr_data,
  input  logic             publish,
  input  logic [CH_W-1:0]  rd_sel,
  output logic [RES_W-1:0] rd_data
);

  logic [RES_W-1:0] shadow    [NUM_CH];
  logic [RES_W-1:0] published [NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i]    <= '0;
        published[i] <= '0;
      end
    end else begin
      if (wr_en) shadow[wr_idx] <= wr_data;
      // Every channel moves in one edge so a reader never sees a mixed set.
      if (publish) begin
        for (int i = 0; i < NUM_CH; i++) published[i] <= shadow[i];
      end
    end
  end

  assign rd_data = published[rd_sel];

endmodule

// File: rtl/ir_sample_seq.sv
// Periodic IR channel acquisition sequencer feeding the IR_vld/sel reader interface.
// Optional build macro IR_AMBIENT_CANCEL_EN adds an emitter-off conversion per channel.
//
//  state      | meaning
//  -----------+----------------------------------------------------------
//  ST_IDLE    | waiting for a period tick
//  ST_SETTLE  | emitter on, waiting SETTLE_CYC cycles before a lit conversion
//  ST_CONV    | one-cycle strt_cnv to the A2D for channel ch
//  ST_WAIT    | waiting for cnv_cmplt, bounded by TIMEOUT cycles
//  ST_NEXT    | advance to the next channel or finish the set
//  ST_PUBLISH | published bank just updated; IR_vld high for this cycle
module ir_sample_seq
  import ir_pkg::*;
#(
  parameter int PERIOD     = 65536,
  parameter int SETTLE_CYC = 1024,
  parameter int TIMEOUT    = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             strt_cnv,
  output logic [CH_W-1:0]  chnnl,
  input  logic             cnv_cmplt,
  input  logic [RES_W-1:0] res,
  output logic             IR_en,
  input  logic [CH_W-1:0]  rd_sel,
  output logic [RES_W-1:0] rd_data,
  output logic             IR_vld,
  output logic             timeout_err
);

  localparam int PW   = $clog2(PERIOD);
  localparam int TMAX = (SETTLE_CYC > TIMEOUT) ? SETTLE_CYC : TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [PW-1:0]   PER_LAST = PW'(PERIOD - 1);
  localparam logic [TW-1:0]   SET_LOAD = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0]   TMO_LOAD = TW'(TIMEOUT - 1);
  localparam logic [CH_W-1:0] CH_LAST  = CH_W'(NUM_CH - 1);

  ir_state_t        state, state_nxt;
  logic [PW-1:0]    per_cnt;
  logic             tick;
  logic [TW-1:0]    tmr;
  logic [CH_W-1:0]  ch;
  logic             ir_en_q;
  logic             err_q;
  logic             last_ch;
  logic             wr_en;
  logic [RES_W-1:0] wr_data;
  logic             publish;

`ifdef IR_AMBIENT_CANCEL_EN
  logic             lit;
  logic [RES_W-1:0] amb;
`endif

  assign tick    = (per_cnt == PER_LAST);
  assign last_ch = (ch == CH_LAST);

  always_ff @(posedge clk) begin
    if (rst || !en)  per_cnt <= '0;
    else if (tick)   per_cnt <= '0;
    else             per_cnt <= per_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
`ifdef IR_AMBIENT_CANCEL_EN
        if (tick) state_nxt = ST_CONV;
`else
        if (tick) state_nxt = ST_SETTLE;
`endif
      end
      ST_SETTLE: if (tmr == '0) state_nxt = ST_CONV;
      ST_CONV:   state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (cnv_cmplt) begin
`ifdef IR_AMBIENT_CANCEL_EN
          state_nxt = lit ? ST_NEXT : ST_SETTLE;
`else
          state_nxt = ST_NEXT;
`endif
        end else if (tmr == '0) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_NEXT:    state_nxt = last_ch ? ST_PUBLISH : ST_CONV;
      ST_PUBLISH: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Publishing on the edge into ST_PUBLISH means the new set is readable while IR_vld is high.
  always_comb begin
    publish = (state == ST_NEXT) && last_ch;
`ifdef IR_AMBIENT_CANCEL_EN
    wr_en   = (state == ST_WAIT) && cnv_cmplt && lit;
    wr_data = sat_sub(res, amb);
`else
    wr_en   = (state == ST_WAIT) && cnv_cmplt;
    wr_data = res;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch      <= '0;
      tmr     <= '0;
      ir_en_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef IR_AMBIENT_CANCEL_EN
      lit     <= 1'b0;
      amb     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick) begin
            ch  <= '0;
            tmr <= SET_LOAD;
`ifdef IR_AMBIENT_CANCEL_EN
            ir_en_q <= 1'b0;
            lit     <= 1'b0;
`else
            ir_en_q <= 1'b1;
`endif
          end
        end
        ST_SETTLE: if (tmr != '0) tmr <= tmr - 1'b1;
        ST_CONV:   tmr <= TMO_LOAD;
        ST_WAIT: begin
          if (cnv_cmplt) begin
`ifdef IR_AMBIENT_CANCEL_EN
            if (!lit) begin
              amb     <= res;
              lit     <= 1'b1;
              ir_en_q <= 1'b1;
              tmr     <= SET_LOAD;
            end else begin
              lit     <= 1'b0;
              ir_en_q <= 1'b0;
            end
`endif
          end else if (tmr == '0) begin
            err_q   <= 1'b1;
            ir_en_q <= 1'b0;
`ifdef IR_AMBIENT_CANCEL_EN
            lit     <= 1'b0;
`endif
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_NEXT: begin
          if (last_ch) ir_en_q <= 1'b0;
          else         ch      <= ch + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign strt_cnv    = (state == ST_CONV);
  assign IR_vld      = (state == ST_PUBLISH);
  assign chnnl       = ch;
  assign IR_en       = ir_en_q;
  assign timeout_err = err_q;

  ir_sample_bank u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (ch),
    .wr_data (wr_data),
    .publish (publish),
    .rd_sel  (rd_sel),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_ir_sample_seq.sv
// Directed bench for ir_sample_seq with a behavioural A2D (5-cycle latency) and pulse monitor.
// Shortened timing parameters keep each scenario to a few hundred cycles.
module tb_ir_sample_seq;
  import ir_pkg::*;

  localparam int PERIOD     = 512;
  localparam int SETTLE_CYC = 8;
  localparam int TIMEOUT    = 20;
`ifdef IR_AMBIENT_CANCEL_EN
  localparam int CPC = 2;
`else
  localparam int CPC = 1;
`endif
  localparam int NCONV = NUM_CH * CPC;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             strt_cnv;
  logic [CH_W-1:0]  chnnl;
  logic             cnv_cmplt = 1'b0;
  logic [RES_W-1:0] res = '0;
  logic             IR_en;
  logic [CH_W-1:0]  rd_sel = '0;
  logic [RES_W-1:0] rd_data;
  logic             IR_vld;
  logic             timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [RES_W-1:0] lit_val [NUM_CH];
  logic [RES_W-1:0] amb_val [NUM_CH];
  int withhold_ch = -1;

  int n_strt = 0;
  int n_vld  = 0;
  logic [CH_W-1:0] strt_log [64];

  always #5 clk = ~clk;

  ir_sample_seq #(
    .PERIOD     (PERIOD),
    .SETTLE_CYC (SETTLE_CYC),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .strt_cnv    (strt_cnv),
    .chnnl       (chnnl),
    .cnv_cmplt   (cnv_cmplt),
    .res         (res),
    .IR_en       (IR_en),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data),
    .IR_vld      (IR_vld),
    .timeout_err (timeout_err)
  );

  // A2D model: result returned 5 cycles after strt_cnv; lit or ambient table chosen by IR_en
  initial begin : a2d_model
    bit               busy;
    int               cnt;
    int               cch;
    logic [RES_W-1:0] val;
    busy = 1'b0; cnt = 0; cch = 0; val = '0;
    forever begin
      @(negedge clk);
      cnv_cmplt = 1'b0;
      if (rst) begin
        busy = 1'b0;
      end else if (busy) begin
        if (cnt == 1) begin
          busy = 1'b0;
          if (cch != withhold_ch) begin
            cnv_cmplt = 1'b1;
            res = val;
          end
        end else begin
          cnt--;
        end
      end else if (strt_cnv) begin
        busy = 1'b1;
        cnt  = 5;
        cch  = int'(chnnl);
        val  = IR_en ? lit_val[chnnl] : amb_val[chnnl];
      end
    end
  end

  initial begin : pulse_monitor
    forever begin
      @(negedge clk);
      if (strt_cnv) begin
        strt_log[n_strt % 64] = chnnl;
        n_strt++;
      end
      if (IR_vld) n_vld++;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_vld(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      step(1);
      if (IR_vld) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_strt(input int ch, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      step(1);
      if (strt_cnv && (ch < 0 || int'(chnnl) == ch)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    step(2);
    n_tests++; if (strt_cnv !== 1'b0) begin n_fail++; $display("FAIL reset_strt_cnv: got %b want 0", strt_cnv); end
    n_tests++; if (chnnl !== 3'd0) begin n_fail++; $display("FAIL reset_chnnl: got %0d want 0", chnnl); end
    n_tests++; if (IR_en !== 1'b0) begin n_fail++; $display("FAIL reset_IR_en: got %b want 0", IR_en); end
    n_tests++; if (IR_vld !== 1'b0) begin n_fail++; $display("FAIL reset_IR_vld: got %b want 0", IR_vld); end
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    for (int k = 0; k < NUM_CH; k++) begin
      rd_sel = CH_W'(k);
      #1;
      n_tests++; if (rd_data !== 12'd0) begin n_fail++; $display("FAIL reset_rd_data[%0d]: got %0d want 0", k, rd_data); end
    end
    rst = 1'b0;
  endtask

  task automatic test_single_set();
    bit ok;
    int bs, bv;
    for (int k = 0; k < NUM_CH; k++) begin
      lit_val[k] = RES_W'(100 * (k + 1));
      amb_val[k] = '0;
    end
    bs = n_strt;
    bv = n_vld;
    en = 1'b1;
    wait_vld(PERIOD + 200, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL set_ir_vld_seen: got %b want 1", ok); end
    step(1);
    n_tests++; if (IR_vld !== 1'b0) begin n_fail++; $display("FAIL set_ir_vld_width: got %b want 0", IR_vld); end
    n_tests++; if (IR_en !== 1'b0) begin n_fail++; $display("FAIL set_ir_en_off: got %b want 0", IR_en); end
    n_tests++; if (n_strt - bs !== NCONV) begin n_fail++; $display("FAIL set_strt_count: got %0d want %0d", n_strt - bs, NCONV); end
    n_tests++; if (n_vld - bv !== 1) begin n_fail++; $display("FAIL set_vld_count: got %0d want 1", n_vld - bv); end
    for (int i = 0; i < NCONV; i++) begin
      n_tests++;
      if (strt_log[(bs + i) % 64] !== CH_W'(i / CPC)) begin
        n_fail++; $display("FAIL set_chnnl_order[%0d]: got %0d want %0d", i, strt_log[(bs + i) % 64], i / CPC);
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      rd_sel = CH_W'(k);
      #1;
      n_tests++; if (rd_data !== RES_W'(100 * (k + 1))) begin n_fail++; $display("FAIL set_rd_data[%0d]: got %0d want %0d", k, rd_data, 100 * (k + 1)); end
    end
  endtask

  task automatic test_reader_during_next_set();
    bit ok;
    int bs;
    for (int k = 0; k < NUM_CH; k++) lit_val[k] = 12'hFFF;
    bs = n_strt;
    ok = 1'b0;
    for (int i = 0; i < PERIOD + 200; i++) begin
      @(negedge clk);
      rd_sel = CH_W'(i % NUM_CH);
      #1;
      if (IR_vld) begin
        ok = 1'b1;
        break;
      end
      n_tests++;
      if (rd_data !== RES_W'(100 * (i % NUM_CH + 1))) begin
        n_fail++; $display("FAIL reader_hold cycle %0d sel %0d: got %0d want %0d", i, i % NUM_CH, rd_data, 100 * (i % NUM_CH + 1));
      end
    end
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL reader_next_vld: got %b want 1", ok); end
    n_tests++; if (n_strt - bs !== NCONV) begin n_fail++; $display("FAIL reader_strt_count: got %0d want %0d", n_strt - bs, NCONV); end
    step(1);
    for (int k = 0; k < NUM_CH; k++) begin
      rd_sel = CH_W'(k);
      #1;
      n_tests++; if (rd_data !== 12'hFFF) begin n_fail++; $display("FAIL reader_new_set[%0d]: got %h want fff", k, rd_data); end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int bv, cyc;
    for (int k = 0; k < NUM_CH; k++) lit_val[k] = RES_W'(100 * (k + 1) + 5);
    withhold_ch = 3;
    bv = n_vld;
    wait_strt(3, PERIOD + 200, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL tmo_ch3_strt: got %b want 1", ok); end
    cyc = 0;
    while (timeout_err == 1'b0 && cyc < TIMEOUT + 50) begin
      step(1);
      cyc++;
    end
    n_tests++; if (cyc !== TIMEOUT + 1) begin n_fail++; $display("FAIL tmo_latency: got %0d want %0d", cyc, TIMEOUT + 1); end
    n_tests++; if (IR_en !== 1'b0) begin n_fail++; $display("FAIL tmo_ir_en: got %b want 0", IR_en); end
    step(10);
    n_tests++; if (n_vld - bv !== 0) begin n_fail++; $display("FAIL tmo_no_vld: got %0d want 0", n_vld - bv); end
    n_tests++; if (strt_cnv !== 1'b0) begin n_fail++; $display("FAIL tmo_idle_strt: got %b want 0", strt_cnv); end
    for (int k = 0; k < NUM_CH; k++) begin
      rd_sel = CH_W'(k);
      #1;
      n_tests++; if (rd_data !== 12'hFFF) begin n_fail++; $display("FAIL tmo_retained[%0d]: got %h want fff", k, rd_data); end
    end
    withhold_ch = -1;
    wait_strt(-1, PERIOD + 200, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL tmo_restart_seen: got %b want 1", ok); end
    n_tests++; if (chnnl !== 3'd0) begin n_fail++; $display("FAIL tmo_restart_ch: got %0d want 0", chnnl); end
    n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
  endtask

  task automatic test_reset_mid_set();
    bit ok;
    int bv, bs;
    wait_strt(5, 400, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rstmid_ch5_strt: got %b want 1", ok); end
    step(2);
    bv = n_vld;
    rst = 1'b1;
    step(1);
    n_tests++; if (strt_cnv !== 1'b0) begin n_fail++; $display("FAIL rstmid_strt_cnv: got %b want 0", strt_cnv); end
    n_tests++; if (chnnl !== 3'd0) begin n_fail++; $display("FAIL rstmid_chnnl: got %0d want 0", chnnl); end
    n_tests++; if (IR_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_IR_en: got %b want 0", IR_en); end
    n_tests++; if (IR_vld !== 1'b0) begin n_fail++; $display("FAIL rstmid_IR_vld: got %b want 0", IR_vld); end
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_timeout_err: got %b want 0", timeout_err); end
    for (int k = 0; k < NUM_CH; k++) begin
      rd_sel = CH_W'(k);
      #1;
      n_tests++; if (rd_data !== 12'd0) begin n_fail++; $display("FAIL rstmid_bank[%0d]: got %0d want 0", k, rd_data); end
    end
    rst = 1'b0;
    bs = n_strt;
    step(40);
    n_tests++; if (n_vld - bv !== 0) begin n_fail++; $display("FAIL rstmid_no_vld: got %0d want 0", n_vld - bv); end
    n_tests++; if (n_strt - bs !== 0) begin n_fail++; $display("FAIL rstmid_no_strt: got %0d want 0", n_strt - bs); end
  endtask

  task automatic test_en_drop();
    bit ok;
    int bs;
    wait_strt(-1, PERIOD + 200, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL endrop_strt: got %b want 1", ok); end
    en = 1'b0;
    wait_vld(400, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL endrop_completes: got %b want 1", ok); end
    for (int k = 0; k < NUM_CH; k++) begin
      rd_sel = CH_W'(k);
      #1;
      n_tests++; if (rd_data !== RES_W'(100 * (k + 1) + 5)) begin n_fail++; $display("FAIL endrop_rd_data[%0d]: got %0d want %0d", k, rd_data, 100 * (k + 1) + 5); end
    end
    bs = n_strt;
    step(PERIOD + 100);
    n_tests++; if (n_strt - bs !== 0) begin n_fail++; $display("FAIL endrop_no_new_set: got %0d want 0", n_strt - bs); end
  endtask

`ifdef IR_AMBIENT_CANCEL_EN
  task automatic test_ambient_cancel();
    bit ok;
    int bs;
    logic [RES_W-1:0] expv [NUM_CH];
    amb_val[0] = 12'd300;  lit_val[0] = 12'd1000; expv[0] = 12'd700;
    amb_val[1] = 12'd900;  lit_val[1] = 12'd800;  expv[1] = 12'd0;
    amb_val[2] = 12'd1000; lit_val[2] = 12'd1000; expv[2] = 12'd0;
    amb_val[3] = 12'd0;    lit_val[3] = 12'd4095; expv[3] = 12'd4095;
    amb_val[4] = 12'd10;   lit_val[4] = 12'd14;   expv[4] = 12'd4;
    amb_val[5] = 12'd10;   lit_val[5] = 12'd15;   expv[5] = 12'd5;
    amb_val[6] = 12'd10;   lit_val[6] = 12'd16;   expv[6] = 12'd6;
    amb_val[7] = 12'd10;   lit_val[7] = 12'd17;   expv[7] = 12'd7;
    bs = n_strt;
    en = 1'b1;
    wait_vld(PERIOD + 400, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL amb_vld_seen: got %b want 1", ok); end
    n_tests++; if (n_strt - bs !== 16) begin n_fail++; $display("FAIL amb_strt_count: got %0d want 16", n_strt - bs); end
    for (int k = 0; k < NUM_CH; k++) begin
      rd_sel = CH_W'(k);
      #1;
      n_tests++; if (rd_data !== expv[k]) begin n_fail++; $display("FAIL amb_rd_data[%0d]: got %0d want %0d", k, rd_data, expv[k]); end
    end
    en = 1'b0;
  endtask
`endif

  initial begin
    for (int k = 0; k < NUM_CH; k++) begin
      lit_val[k] = '0;
      amb_val[k] = '0;
    end
    test_reset();
    test_single_set();
    test_reader_during_next_set();
    test_timeout();
    test_reset_mid_set();
    test_en_drop();
`ifdef IR_AMBIENT_CANCEL_EN
    test_ambient_cancel();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
